multi_digit_adder_display: RTL and testbench

- Parametrised, clocked successor to the single-digit adder/display path.
- Registers two WIDTH-bit operands on a load strobe, then computes A+B+CI or |A−B|.
- Converts the result to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a DIGITS-wide time-multiplexed active-low seven-segment display with leading-zero blanking, overflow dashes and a negative indicator.
- Sits between board switches/buttons and the seven-segment/anode pins.

---
 rtl/multi_digit_adder_display.sv | 230 +++++++++++++++++++++++
 tb/tb_multi_digit_adder_display.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_adder_display.sv
// multi_digit_adder_display
//   Captures two WIDTH-bit operands on a load strobe. It then computes either
//   A+B+CI or |A-B|, converts the result to BCD with a sequential double-dabble
//   engine, and drives a time-multiplexed active-low seven-segment display.
//   The display blanks leading zeros, shows dashes on overflow and uses the
//   decimal point of the top digit as the negative indicator.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   A1, B1            operands (WIDTH bits)
//   CI                carry-in, add mode only
//   sub               0 = add, 1 = subtract (magnitude)
//   load              single-cycle start strobe, ignored while busy
//   busy              conversion in progress
//   done              one-cycle pulse when the new result reaches the display
//   CO                add: carry-out; sub: 1 when A1 >= B1
//   neg               sub mode and A1 < B1
//   seg               {g,f,e,d,c,b,a}, active-low
//   an                digit enables, active-low, an[0] = least-significant digit
//   dp                decimal point, active-low
module multi_digit_adder_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A1,
  input  logic [WIDTH-1:0]  B1,
  input  logic              CI,
  input  logic              sub,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              CO,
  output logic              neg,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int RW  = WIDTH + 1;
  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(WIDTH + 2);
  localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RCW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH + 1);
  localparam logic [SW-1:0]  LAST_SCAN = SW'(DIGITS - 1);
  localparam logic [RCW-1:0] LAST_REF  = RCW'(REFRESH_DIV - 1);

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [BW-1:0] add3_adjust(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Per-digit blank mask: a digit is blank when it and every digit above it is
  // zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BW-1:0] v);
    logic [DIGITS-1:0] m;
    logic              nz;
    m  = '0;
    nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz   = nz | (v[4*i +: 4] != 4'd0);
      m[i] = ~nz & (i != 0);
    end
    return m;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic              busy_r, done_r, co_r, neg_r;
  logic [RW-1:0]     bin_r;
  logic [BW-1:0]     bcd_r;
  logic              ovf_work_r;
  logic [CW-1:0]     iter_r;
  logic [BW-1:0]     disp_bcd_r;
  logic              disp_ovf_r;
  logic [RCW-1:0]    ref_cnt_r;
  logic [SW-1:0]     scan_r;
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;
  logic              dp_r;

  logic [RW-1:0]     sum_s;
  logic [WIDTH-1:0]  diff_s;
  logic              a_ge_b_s;
  logic [RW-1:0]     result_s;
  logic [BW-1:0]     adj_s;
  logic [DIGITS-1:0] blank_s;
  logic [3:0]        cur_nib_s;
  logic [6:0]        seg_next_s;
  logic              dp_next_s;

  // Arithmetic on the live inputs; only sampled on an accepted load.
  always_comb begin
    sum_s    = {1'b0, A1} + {1'b0, B1} + {{WIDTH{1'b0}}, CI};
    a_ge_b_s = (A1 >= B1);
    if (a_ge_b_s) begin
      diff_s = A1 - B1;
    end else begin
      diff_s = B1 - A1;
    end
    if (sub) begin
      result_s = {1'b0, diff_s};
    end else begin
      result_s = sum_s;
    end
  end

  assign adj_s = add3_adjust(bcd_r);

  // Load capture, double-dabble iterations and commit to the display buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      co_r       <= 1'b0;
      neg_r      <= 1'b0;
      bin_r      <= '0;
      bcd_r      <= '0;
      ovf_work_r <= 1'b0;
      iter_r     <= '0;
      disp_bcd_r <= '0;
      disp_ovf_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!busy_r) begin
        if (load) begin
          busy_r     <= 1'b1;
          co_r       <= sub ? a_ge_b_s : sum_s[WIDTH];
          neg_r      <= sub & ~a_ge_b_s;
          bin_r      <= result_s;
          bcd_r      <= '0;
          ovf_work_r <= 1'b0;
          iter_r     <= '0;
        end
      end else if (iter_r == LAST_ITER) begin
        // All WIDTH+1 shifts are done: publish the result.
        busy_r     <= 1'b0;
        done_r     <= 1'b1;
        disp_bcd_r <= bcd_r;
        disp_ovf_r <= ovf_work_r;
      end else begin
        // The bit leaving the top nibble means the value needs more digits.
        bcd_r      <= {adj_s[BW-2:0], bin_r[RW-1]};
        bin_r      <= {bin_r[RW-2:0], 1'b0};
        ovf_work_r <= ovf_work_r | adj_s[BW-1];
        iter_r     <= iter_r + 1'b1;
      end
    end
  end

  assign blank_s   = blank_mask(disp_bcd_r);
  assign cur_nib_s = disp_bcd_r[{scan_r, 2'b00} +: 4];

  // Segment and decimal-point pattern for the digit currently selected.
  always_comb begin
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (disp_ovf_r) begin
      seg_next_s = 7'b0111111;
    end else if (blank_s[scan_r]) begin
      seg_next_s = 7'h7F;
    end else begin
      seg_next_s = bcd_to_seg(cur_nib_s);
    end
    if ((scan_r == LAST_SCAN) && neg_r) begin
      dp_next_s = 1'b0;
    end else begin
      dp_next_s = 1'b1;
    end
  end

  // Refresh divider, scan index and registered display pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_r <= '0;
      scan_r    <= '0;
      seg_r     <= 7'h7F;
      an_r      <= '1;
      dp_r      <= 1'b1;
    end else begin
      if (ref_cnt_r == LAST_REF) begin
        ref_cnt_r <= '0;
        scan_r    <= (scan_r == LAST_SCAN) ? '0 : scan_r + 1'b1;
      end else begin
        ref_cnt_r <= ref_cnt_r + 1'b1;
      end
      seg_r <= seg_next_s;
      an_r  <= ~(DIGITS'(1) << scan_r);
      dp_r  <= dp_next_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign CO   = co_r;
  assign neg  = neg_r;
  assign seg  = seg_r;
  assign an   = an_r;
  assign dp   = dp_r;

endmodule

// File: tb/tb_multi_digit_adder_display.sv
module tb_multi_digit_adder_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a1 = 8'd0;
  logic [7:0] b1 = 8'd0;
  logic       ci = 1'b0;
  logic       sub = 1'b0;
  logic       load = 1'b0;

  logic       busy4, done4, co4, neg4, dp4;
  logic [6:0] seg4;
  logic [3:0] an4;
  logic       busy2, done2, co2, neg2, dp2;
  logic [6:0] seg2;
  logic [1:0] an2;

  int n_checks = 0;
  int n_errors = 0;

  multi_digit_adder_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .A1(a1), .B1(b1), .CI(ci), .sub(sub), .load(load),
    .busy(busy4), .done(done4), .CO(co4), .neg(neg4), .seg(seg4), .an(an4), .dp(dp4)
  );

  multi_digit_adder_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
    .clk(clk), .rst(rst), .A1(a1), .B1(b1), .CI(ci), .sub(sub), .load(load),
    .busy(busy2), .done(done2), .CO(co2), .neg(neg2), .seg(seg2), .an(an2), .dp(dp2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            ci;
    logic            sub;
    logic            co;
    logic            ng;
    logic [3:0][6:0] s4;
    logic [1:0][6:0] s2;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic c,
                              input logic s, input logic co, input logic ng,
                              input logic [3:0][6:0] s4, input logic [1:0][6:0] s2);
    vec_t v;
    v.a = a; v.b = b; v.ci = c; v.sub = s; v.co = co; v.ng = ng; v.s4 = s4; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Pulse load for one edge, then count cycles until done (bounded).
  task automatic start_load(input logic [7:0] a, input logic [7:0] b, input logic c,
                            input logic s);
    a1 = a; b1 = b; ci = c; sub = s; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input int start_lat, input string tag);
    int lat;
    lat = start_lat;
    while (lat < 40 && !done4) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 10);
    chk({tag, " done2"}, done2, 1'b1);
    chk({tag, " busy after done"}, busy4, 1'b0);
    @(negedge clk);
    chk({tag, " done width"}, done4, 1'b0);
  endtask

  // Watch a full scan on both instances and compare every lit digit.
  task automatic scan_check(input logic [3:0][6:0] e4, input logic [1:0][6:0] e2,
                            input logic ng, input string tag);
    logic [3:0] seen4;
    logic [1:0] seen2;
    int idx;
    seen4 = 4'h0;
    seen2 = 2'h0;
    for (int t = 0; t < 20; t++) begin
      chk({tag, " an4 onehot"}, $countones(~an4), 1);
      chk({tag, " an2 onehot"}, $countones(~an2), 1);
      idx = 0;
      for (int k = 0; k < 4; k++) if (!an4[k]) idx = k;
      seen4[idx] = 1'b1;
      chk($sformatf("%s seg4 d%0d", tag, idx), seg4, e4[idx]);
      chk($sformatf("%s dp4 d%0d", tag, idx), dp4, (idx == 3 && ng) ? 1'b0 : 1'b1);
      idx = an2[0] ? 1 : 0;
      seen2[idx] = 1'b1;
      chk($sformatf("%s seg2 d%0d", tag, idx), seg2, e2[idx]);
      chk($sformatf("%s dp2 d%0d", tag, idx), dp2, (idx == 1 && ng) ? 1'b0 : 1'b1);
      @(negedge clk);
    end
    chk({tag, " all digits scanned4"}, seen4, 4'hF);
    chk({tag, " all digits scanned2"}, seen2, 2'h3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;

    vecs[0] = mk(8'd25,  8'd17,  1'b1, 1'b0, 1'b0, 1'b0, {BL, BL, S4, S3}, {S4, S3});
    vecs[1] = mk(8'd255, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0, {BL, S5, S1, S1}, {DS, DS});
    vecs[2] = mk(8'd10,  8'd200, 1'b1, 1'b1, 1'b0, 1'b1, {BL, S1, S9, S0}, {DS, DS});
    vecs[3] = mk(8'd200, 8'd10,  1'b0, 1'b1, 1'b1, 1'b0, {BL, S1, S9, S0}, {DS, DS});
    vecs[4] = mk(8'd60,  8'd50,  1'b0, 1'b0, 1'b0, 1'b0, {BL, S1, S1, S0}, {DS, DS});
    vecs[5] = mk(8'd1,   8'd2,   1'b0, 1'b0, 1'b0, 1'b0, {BL, BL, BL, S3}, {BL, S3});
    vecs[6] = mk(8'd7,   8'd7,   1'b0, 1'b1, 1'b1, 1'b0, {BL, BL, BL, S0}, {BL, S0});
    vecs[7] = mk(8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 1'b0, {BL, BL, BL, S0}, {BL, S0});
    vecs[8] = mk(8'd128, 8'd128, 1'b0, 1'b0, 1'b1, 1'b0, {BL, S2, S5, S6}, {DS, DS});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", busy4, 1'b0);
    chk("rst done", done4, 1'b0);
    chk("rst CO", co4, 1'b0);
    chk("rst neg", neg4, 1'b0);
    chk("rst seg", seg4, 7'h7F);
    chk("rst an4", an4, 4'hF);
    chk("rst an2", an2, 2'h3);
    chk("rst dp", dp4, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    scan_check({BL, BL, BL, S0}, {BL, S0}, 1'b0, "post-reset");

    for (int i = 0; i < 9; i++) begin
      start_load(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
      chk($sformatf("v%0d busy", i), busy4, 1'b1);
      chk($sformatf("v%0d CO", i), co4, vecs[i].co);
      chk($sformatf("v%0d neg", i), neg4, vecs[i].ng);
      chk($sformatf("v%0d CO2", i), co2, vecs[i].co);
      wait_done(0, $sformatf("v%0d", i));
      scan_check(vecs[i].s4, vecs[i].s2, vecs[i].ng, $sformatf("v%0d", i));
    end

    // Busy ignore: a second load two cycles in must not disturb the first.
    start_load(8'd99, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    start_load(8'd1, 8'd1, 1'b0, 1'b0);
    chk("ignore busy", busy4, 1'b1);
    wait_done(2, "ignore");
    scan_check({BL, S1, S0, S0}, {DS, DS}, 1'b0, "ignore");

    // Reset mid-conversion: no done, display back to "0".
    start_load(8'd25, 8'd17, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst busy before", busy4, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy4, 1'b0);
    chk("midrst done", done4, 1'b0);
    chk("midrst an", an4, 4'hF);
    chk("midrst seg", seg4, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done4) seen_done = 1'b1;
    end
    chk("midrst no done", seen_done, 1'b0);
    chk("midrst CO", co4, 1'b0);
    scan_check({BL, BL, BL, S0}, {BL, S0}, 1'b0, "midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
